regfile_we_sequencer: RTL and testbench



---
 rtl/regfile_we_sequencer.sv | 127 ++++++++++++
 tb/tb_regfile_we_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_we_sequencer.sv
// regfile_we_sequencer
// Registered write-enable decoder for the register file. Each cycle the accepted
// write-select requests are decoded to a (multi-)hot enable vector that appears one
// cycle later. A clear sweep walks a one-hot enable across every register, one per
// cycle, so the file can be zeroed after boot or a flush.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   wr_valid     per-port write request
//   wr_sel       per-port register index, port p at [p*SEL_W +: SEL_W]
//   wr_ready     common accept for all ports (low during a sweep or while clr_req is high)
//   clr_req      start a clear sweep (sampled only while idle)
//   clr_busy     sweep in progress
//   clr_done     one-cycle pulse with the final sweep output
//   we_out       registered write-enable vector
//   err_collide  registered pulse when accepted ports target the same register
module regfile_we_sequencer #(
  parameter int unsigned SEL_W    = 5,
  parameter int unsigned NUM_WR   = 1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_WR-1:0]         wr_valid,
  input  logic [NUM_WR*SEL_W-1:0]   wr_sel,
  output logic                      wr_ready,
  input  logic                      clr_req,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic [(2**SEL_W)-1:0]     we_out,
  output logic                      err_collide
);

  localparam int unsigned OUT_W = 2 ** SEL_W;

  typedef enum logic {StIdle, StSweep} state_e;

  state_e              state_q;
  logic [SEL_W-1:0]    cnt_q;

  logic [NUM_WR-1:0]   accepted;
  logic [OUT_W-1:0]    write_vec;
  logic [OUT_W-1:0]    sweep_vec;
  logic                collide;

  assign wr_ready = (state_q == StIdle) && !clr_req;
  assign clr_busy = (state_q == StSweep);
  assign accepted = wr_valid & {NUM_WR{wr_ready}};

  // OR of the one-hot decodes of every accepted port; duplicates simply merge.
  always_comb begin
    write_vec = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (accepted[p]) begin
        write_vec[wr_sel[p*SEL_W +: SEL_W]] = 1'b1;
      end
    end
    if (ZERO_REG) begin
      write_vec[OUT_W-1] = 1'b0;
    end
  end

  // Pairwise compare of accepted selects. Writes to the hardwired zero register
  // are dropped anyway, so they never count as a collision.
  always_comb begin
    collide = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      for (int q = p + 1; q < NUM_WR; q++) begin
        if (accepted[p] && accepted[q] &&
            (wr_sel[p*SEL_W +: SEL_W] == wr_sel[q*SEL_W +: SEL_W]) &&
            !(ZERO_REG && (&wr_sel[p*SEL_W +: SEL_W]))) begin
          collide = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sweep_vec        = '0;
    sweep_vec[cnt_q] = 1'b1;
    if (ZERO_REG) begin
      sweep_vec[OUT_W-1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_out      <= '0;
      clr_done    <= 1'b0;
      err_collide <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            // Index 0 is emitted on the starting edge; cnt already points at 1.
            we_out      <= {{(OUT_W-1){1'b0}}, 1'b1};
            cnt_q       <= {{(SEL_W-1){1'b0}}, 1'b1};
            err_collide <= 1'b0;
            state_q     <= StSweep;
          end else begin
            we_out      <= write_vec;
            err_collide <= collide;
          end
        end
        StSweep: begin
          we_out      <= sweep_vec;
          cnt_q       <= cnt_q + 1'b1;
          err_collide <= 1'b0;
          if (&cnt_q) begin
            clr_done <= 1'b1;
            state_q  <= StIdle;
          end else begin
            clr_done <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_we_sequencer.sv
module tb_regfile_we_sequencer;

  localparam int SEL_W  = 5;
  localparam int NUM_WR = 2;
  localparam int OUT_W  = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        wr_valid = 2'b11;
  logic [9:0]        wr_sel = '0;
  logic              wr_ready;
  logic              clr_req = 1'b0;
  logic              clr_busy;
  logic              clr_done;
  logic [OUT_W-1:0]  we_out;
  logic              err_collide;

  regfile_we_sequencer #(
    .SEL_W    (SEL_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_valid    (wr_valid),
    .wr_sel      (wr_sel),
    .wr_ready    (wr_ready),
    .clr_req     (clr_req),
    .clr_busy    (clr_busy),
    .clr_done    (clr_done),
    .we_out      (we_out),
    .err_collide (err_collide)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] we;
    logic        col;
    logic        done;
    logic        busy;
  } exp_t;

  exp_t sb[$];        // expected outputs, tagged with the cycle they belong to
  int   sweep_q[$];   // register indices still to be cleared by the model
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
    end
  endtask

  // Monitor: at each falling edge compare the outputs registered at the last rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          mon_e = sb.pop_front();
          if (mon_e.cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL stale_entry cyc=%0d got=none want=cycle_%0d", cyc, mon_e.cyc);
          end else begin
            check("we_out", we_out, mon_e.we);
            check("err_collide", err_collide, mon_e.col);
            check("clr_done", clr_done, mon_e.done);
            check("clr_busy", clr_busy, mon_e.busy);
          end
        end
      end
    end
  end

  // Drive one cycle of inputs (called #1 after a rising edge), predict the
  // outputs of the next edge from the model, and check the combinational ready.
  task automatic step(input logic [1:0] v, input logic [4:0] s0, input logic [4:0] s1,
                      input logic clr);
    exp_t        e;
    logic [31:0] we;
    logic        ready;
    int          sels[2];
    int          idx;
    wr_valid = v;
    wr_sel   = {s1, s0};
    clr_req  = clr;
    we       = '0;
    e.cyc    = cyc + 1;
    e.col    = 1'b0;
    e.done   = 1'b0;
    sels[0]  = int'(s0);
    sels[1]  = int'(s1);
    if (sweep_q.size() == 0) begin
      ready = !clr;
      if (clr) begin
        for (int i = 0; i < OUT_W; i++) sweep_q.push_back(i);
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (v[p] && sels[p] != OUT_W - 1) we[sels[p]] = 1'b1;
        end
        e.col = (v == 2'b11) && (s0 == s1) && (sels[0] != OUT_W - 1);
      end
    end else begin
      ready = 1'b0;
    end
    if (sweep_q.size() > 0) begin
      idx = sweep_q.pop_front();
      if (idx != OUT_W - 1) we[idx] = 1'b1;
      e.done = (sweep_q.size() == 0);
    end
    e.busy = (sweep_q.size() > 0);
    e.we   = we;
    sb.push_back(e);
    #1;
    check("wr_ready", {31'b0, wr_ready}, {31'b0, ready});
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, we_out, 32'h0);
    check({tag, "_busy"}, {31'b0, clr_busy}, 32'h0);
    check({tag, "_done"}, {31'b0, clr_done}, 32'h0);
    check({tag, "_col"}, {31'b0, err_collide}, 32'h0);
    check({tag, "_ready"}, {31'b0, wr_ready}, 32'h1);
  endtask

  // Asserted mid-cycle so clearing must be asynchronous; held across two edges
  // with both write requests high.
  task automatic do_reset();
    #2;
    clr_req  = 1'b0;
    wr_valid = 2'b11;
    reset_n  = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    sb.delete();
    sweep_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    reset_n = 1'b1;
  endtask

  logic [4:0] r0, r1;

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Single writes and zero-register masking.
    step(2'b01, 5'd5, 5'd0, 1'b0);
    step(2'b00, 5'd0, 5'd0, 1'b0);
    step(2'b10, 5'd0, 5'd31, 1'b0);
    // Dual writes: distinct, colliding, colliding on the masked register.
    step(2'b11, 5'd3, 5'd17, 1'b0);
    step(2'b11, 5'd9, 5'd9, 1'b0);
    step(2'b11, 5'd31, 5'd31, 1'b0);
    step(2'b00, 5'd0, 5'd0, 1'b0);

    // Sweep from a clr_req pulse with a write held pending throughout.
    step(2'b01, 5'd7, 5'd0, 1'b1);
    repeat (33) step(2'b01, 5'd7, 5'd0, 1'b0);
    step(2'b00, 5'd0, 5'd0, 1'b0);

    // clr_req held: one full sweep, then an immediate second one.
    repeat (70) step(2'b11, 5'd1, 5'd2, 1'b1);
    step(2'b00, 5'd0, 5'd0, 1'b0);
    while (sweep_q.size() > 0) step(2'b00, 5'd0, 5'd0, 1'b0);
    step(2'b00, 5'd0, 5'd0, 1'b0);

    // Reset part-way through a sweep; no resumption afterwards.
    step(2'b00, 5'd0, 5'd0, 1'b1);
    repeat (9) step(2'b00, 5'd0, 5'd0, 1'b0);
    do_reset();
    step(2'b01, 5'd2, 5'd0, 1'b0);
    repeat (3) step(2'b00, 5'd0, 5'd0, 1'b0);

    // Randomised traffic with biased collisions, zero-register hits and clears.
    for (int n = 0; n < 500; n++) begin
      r0 = 5'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom);
      if ($urandom_range(0, 9) == 0) r0 = 5'd31;
      step(2'($urandom), r0, r1, ($urandom_range(0, 40) == 0));
    end
    step(2'b00, 5'd0, 5'd0, 1'b0);

    @(negedge clk);
    #1;
    check("scoreboard_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
